// File: rtl/mips_seq_alu.sv
// mips_seq_alu: multi-cycle MIPS ALU. It runs the classic single-cycle ALUCtl
// ops in one registered cycle. MULTU and DIVU are iterative shift-add and
// restoring-divide engines that write the internal HI/LO pair. Every op
// reports completion with a one-cycle done pulse.
module mips_seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [3:0]       ALUCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivByZero,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_MFHI = 4'd10;
  localparam logic [3:0] OP_MFLO = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   alu_q, alu_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  // Multiplicand (MUL) or divisor (DIV), frozen for the whole iteration.
  logic [WIDTH-1:0]   opb_q, opb_d;
  // MUL: {partial product, remaining multiplier}; DIV: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf;
  logic [WIDTH-1:0]   sum, diff;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic               last_iter;

  assign sum  = A + B;
  assign diff = A - B;

  // One shift-add step: conditionally add the multiplicand, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring-divide step: shift in the next dividend bit and keep the
  // difference only when it did not go negative.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Result and overflow of the single-cycle ops.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    sc_res = '0;
    sc_ovf = 1'b0;
    unique case (ALUCtl)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_NOR:  sc_res = ~(A | B);
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  sc_res = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: sc_res = WIDTH'(A < B);
      OP_MFHI: sc_res = hi_q;
      OP_MFLO: sc_res = lo_q;
      default: sc_res = '0;
    endcase
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    dbz_d   = 1'b0;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (ALUCtl == OP_MULT) begin
            state_d = MUL;
            opb_d   = A;
            acc_d   = {{WIDTH{1'b0}}, B};
            cnt_d   = '0;
          end else if (ALUCtl == OP_DIV) begin
            if (B == '0) begin
              lo_d   = '1;
              hi_d   = A;
              dbz_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              state_d = DIV;
              opb_d   = B;
              acc_d   = {{WIDTH{1'b0}}, A};
              cnt_d   = '0;
            end
          end else begin
            alu_d  = sc_res;
            zero_d = (sc_res == '0);
            ovf_d  = sc_ovf;
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = IDLE;
          hi_d    = mul_next[2*WIDTH-1:WIDTH];
          lo_d    = mul_next[WIDTH-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = IDLE;
          hi_d    = div_next[2*WIDTH-1:WIDTH];
          lo_d    = div_next[WIDTH-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: the datapath registers are reset too, so an aborted MULTU/DIVU leaves no stale HI/LO behind.
    if (RESET) begin
      state_q <= IDLE;
      alu_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      alu_q   <= alu_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ALUOut    = alu_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign DivByZero = dbz_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_mips_seq_alu.sv
// tb_mips_seq_alu: directed vectors with hand-computed results for a 32-bit
// and an 8-bit instance of mips_seq_alu.
module tb_mips_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start32, zero32, ovf32, dbz32, busy32, done32;
  logic [3:0]  ctl32;
  logic [31:0] a32, b32, out32;
  logic        start8, zero8, ovf8, dbz8, busy8, done8;
  logic [3:0]  ctl8;
  logic [7:0]  a8, b8, out8;

  mips_seq_alu #(.WIDTH(32), .CNT_W(6)) dut32 (
    .CLK(clk), .RESET(rst), .start(start32), .ALUCtl(ctl32), .A(a32), .B(b32),
    .ALUOut(out32), .Zero(zero32), .Overflow(ovf32), .DivByZero(dbz32),
    .busy(busy32), .done(done32)
  );

  mips_seq_alu #(.WIDTH(8), .CNT_W(4)) dut8 (
    .CLK(clk), .RESET(rst), .start(start8), .ALUCtl(ctl8), .A(a8), .B(b8),
    .ALUOut(out8), .Zero(zero8), .Overflow(ovf8), .DivByZero(dbz8),
    .busy(busy8), .done(done8)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one start cycle; returns at the negedge after the accepting edge.
  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start32 = 1'b1; ctl32 = op; a32 = a; b32 = b;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start8 = 1'b1; ctl8 = op; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Count edges until done rises, bounded by 100.
  task automatic wait32(output int n);
    n = 0;
    while (!done32 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait8(output int n);
    n = 0;
    while (!done8 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b1;
    start32 = 1'b0; ctl32 = 4'd0; a32 = '0; b32 = '0;
    start8  = 1'b0; ctl8  = 4'd0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    check("rst_out", out32, 0);
    check("rst_zero", zero32, 1);
    check("rst_ovf", ovf32, 0);
    check("rst_dbz", dbz32, 0);
    check("rst_busy", busy32, 0);
    check("rst_done", done32, 0);
    rst = 1'b0;

    // Put non-zero values in ALUOut and LO before exercising reset mid-op.
    issue32(4'd2, 32'd3, 32'd4);
    check("pre_add", out32, 7);
    issue32(4'd8, 32'd3, 32'd5);
    wait32(n);
    check("pre_mul_lat", n, 32);
    issue32(4'd11, 0, 0);
    check("pre_mflo", out32, 15);

    // Reset at iteration 5 of MULTU 7*9.
    issue32(4'd8, 32'd7, 32'd9);
    check("abort_busy_on", busy32, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy32, 0);
    check("abort_done", done32, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= done32;
    end
    check("abort_no_done", seen, 0);
    check("abort_out", out32, 0);
    check("abort_zero", zero32, 1);
    issue32(4'd10, 0, 0);
    check("abort_hi", out32, 0);
    issue32(4'd11, 0, 0);
    check("abort_lo", out32, 0);

    // Single-cycle ops.
    issue32(4'd2, 32'h7FFF_FFFF, 32'd1);
    check("add_out", out32, 64'h8000_0000);
    check("add_ovf", ovf32, 1);
    check("add_done", done32, 1);
    check("add_busy", busy32, 0);
    @(negedge clk);
    check("add_done_pulse", done32, 0);
    issue32(4'd6, 32'd5, 32'd5);
    check("sub_out", out32, 0);
    check("sub_zero", zero32, 1);
    check("sub_ovf", ovf32, 0);
    issue32(4'd6, 32'h8000_0000, 32'd1);
    check("sub_ovf_out", out32, 64'h7FFF_FFFF);
    check("sub_ovf_flag", ovf32, 1);
    issue32(4'd7, 32'hFFFF_FFFF, 32'd1);
    check("slt", out32, 1);
    issue32(4'd3, 32'hFFFF_FFFF, 32'd1);
    check("sltu", out32, 0);
    issue32(4'd0, 32'h0000_F0F0, 32'h0000_FF00);
    check("and", out32, 64'hF000);
    issue32(4'd1, 32'h0000_F0F0, 32'h0000_FF00);
    check("or", out32, 64'hFFF0);
    issue32(4'd5, 32'h1234, 32'h5678);
    check("undef_out", out32, 0);
    check("undef_done", done32, 1);
    issue32(4'd12, 32'd0, 32'd0);
    check("nor_out", out32, 64'hFFFF_FFFF);
    check("nor_zero", zero32, 0);

    // MULTU max*max, then MFHI/MFLO back-to-back from the done cycle.
    issue32(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_busy", busy32, 1);
    check("mul_done_early", done32, 0);
    wait32(n);
    check("mul_lat", n, 32);
    check("mul_busy_end", busy32, 0);
    check("mul_out_held", out32, 64'hFFFF_FFFF);
    start32 = 1'b1; ctl32 = 4'd10;
    @(negedge clk);
    check("mul_mfhi", out32, 64'hFFFF_FFFE);
    check("mul_mfhi_done", done32, 1);
    ctl32 = 4'd11;
    @(negedge clk);
    check("mul_mflo", out32, 1);
    check("mul_mflo_done", done32, 1);
    start32 = 1'b0;

    // DIVU 100/7.
    issue32(4'd9, 32'd100, 32'd7);
    wait32(n);
    check("div_lat", n, 32);
    check("div_dbz", dbz32, 0);
    issue32(4'd11, 0, 0);
    check("div_lo", out32, 14);
    issue32(4'd10, 0, 0);
    check("div_hi", out32, 2);

    // DIVU 100/0.
    issue32(4'd9, 32'd100, 32'd0);
    check("dbz_done", done32, 1);
    check("dbz_flag", dbz32, 1);
    check("dbz_busy", busy32, 0);
    @(negedge clk);
    check("dbz_flag_pulse", dbz32, 0);
    issue32(4'd11, 0, 0);
    check("dbz_lo", out32, 64'hFFFF_FFFF);
    issue32(4'd10, 0, 0);
    check("dbz_hi", out32, 100);

    // start during a DIVU busy window is ignored; start in the done cycle is taken.
    issue32(4'd9, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start32 = 1'b1; ctl32 = 4'd2; a32 = 32'd1; b32 = 32'd1;
    @(negedge clk);
    start32 = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'd3;
    wait32(n);
    check("ign_lat", 4 + n, 32);
    check("ign_out_held", out32, 100);
    start32 = 1'b1; ctl32 = 4'd2; a32 = 32'd2; b32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    check("ign_next_out", out32, 5);
    check("ign_next_done", done32, 1);
    issue32(4'd11, 0, 0);
    check("ign_lo", out32, 14);

    // WIDTH=8 instance.
    issue8(4'd8, 8'hFF, 8'h02);
    wait8(n);
    check("w8_mul_lat", n, 8);
    issue8(4'd10, 0, 0);
    check("w8_hi", out8, 8'h01);
    issue8(4'd11, 0, 0);
    check("w8_lo", out8, 8'hFE);
    issue8(4'd2, 8'h80, 8'h80);
    check("w8_add_out", out8, 0);
    check("w8_add_ovf", ovf8, 1);
    check("w8_add_zero", zero8, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
